alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter that shares one `alu` instance, including its multi-cycle MUL/DIV path, between two issuing units, e.g. the main pipeline and a coprocessor/CSR sequencer. It sits directly in front of the `alu` and owns the ALU's `valid`/`op`/`a`/`b` inputs. It locks the grant for the full duration of a multi-cycle operation and steers the ALU's `ready`/`result`/`extra_result` back to the winning requester.

## Interface
Parameters:
- `WIDTH`, default 32: operand/result width; must match the attached `alu`.
- `CNT_WIDTH`, default 16: width of the statistics counters.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `req0_valid`, `req1_valid`, input, 1 each: request pending.
- `req0_op`, `req1_op`, input, 8 each: ALU op code (`ALU_OP_*` encoding).
- `req0_a`, `req0_b`, `req1_a`, `req1_b`, input, WIDTH each: operands.
- `req0_ready`, `req1_ready`, output, 1 each: completion pulse for that requester; result is valid in the same cycle.
- `result`, `extra_result`, output, WIDTH each: shared return bus; meaningful only when a `reqN_ready` is high; 0 otherwise.
- `alu_valid`, output, 1: to `alu.valid`.
- `alu_op`, output, 8: to `alu.op`.
- `alu_a`, `alu_b`, output, WIDTH each: to `alu.a` and `alu.b`.
- `alu_ready`, input, 1: from `alu.ready`.
- `alu_result`, `alu_extra_result`, input, WIDTH each: from the ALU.
- `busy`, output, 1: grant locked on an in-flight multi-cycle op.
- `grant_id`, output, 1: requester currently driving the ALU; valid while `alu_valid` is high.
- `stat_grant0`, `stat_grant1`, `stat_conflict`, output, CNT_WIDTH each: statistics counters (see Configuration).

## Operation
- State machine has two states:
  - IDLE: no grant locked.
  - LOCKED: holds `lock_id`.
- Register `last_grant` (1 bit) is the round-robin pointer.
- IDLE, selection rule:
  - If only one `reqN_valid` is high, that requester wins.
  - If both are high, the requester ≠ `last_grant` wins.
  - If neither is high, `alu_valid`=0.
- IDLE, driving the ALU: the winner's op/a/b drive the `alu_*` outputs combinationally, and `alu_valid`=1.
- IDLE, `alu_ready`=1 in the same cycle (single-cycle op):
  - Assert the winner's `reqN_ready`.
  - `result`/`extra_result` = `alu_result`/`alu_extra_result`.
  - `last_grant` ← winner; stay in IDLE.
- IDLE, `alu_ready`=0:
  - Go to LOCKED with `lock_id` ← winner.
  - `last_grant` is unchanged.
- LOCKED, driving the ALU: requester `lock_id` alone drives the ALU. The other requester is ignored even if it has priority.
- LOCKED, `alu_ready`=1:
  - Assert `req[lock_id]_ready` and pass the results through.
  - `last_grant` ← `lock_id`; go to IDLE.
  - The next arbitration happens in the following cycle; there is no same-cycle regrant.
- Requester obligations: hold valid, op, a and b stable from assertion until its ready pulse.
- Protocol violation, `req[lock_id]_valid` drops while LOCKED:
  - Deassert `alu_valid` that cycle; no ready pulse; go to IDLE.
  - `last_grant` is unchanged.
- `busy` = (state == LOCKED). `grant_id` = winner in IDLE, `lock_id` in LOCKED.
- Reset:
  - State ← IDLE; `last_grant` ← 1, so requester 0 wins the first tie.
  - Counters ← 0.
  - While `rst` is high, all outputs are forced to 0: `alu_valid`, `reqN_ready`, `result`, `extra_result`, `busy`, `grant_id`.
- Reset mid-operation: an in-flight MUL/DIV is abandoned. No ready pulse is issued, and both requesters must re-issue.

## Timing
- Single-cycle ops: zero-cycle combinational path, `reqN_valid` → `alu_valid` → `alu_ready` → `reqN_ready` in the same cycle.
- Multi-cycle ops: latency equals the ALU latency. The arbiter adds no cycles; completion occurs in the first cycle `alu_ready`=1.
- Throughput: one completion per cycle. Two back-to-back single-cycle requesters alternate every cycle.
- After a LOCKED completion, the losing requester is granted in the next cycle at the earliest.
- No combinational path from `alu_result` to any `alu_*` output.

## Configuration
- Macro: `ALU_ARB_STATS_EN`.
- Defined:
  - `stat_grant0` / `stat_grant1` increment on every `req0_ready` / `req1_ready` pulse.
  - `stat_conflict` increments on every cycle where both `reqN_valid` are high and exactly one requester receives a ready pulse, or both are waiting (LOCKED with the other valid).
  - All three counters saturate at 2^CNT_WIDTH−1 and clear on `rst`.
- Undefined: the counters are not instantiated and all three stat outputs are constant 0. Functional behaviour is identical.

## Test plan
- Reset release: hold `rst`=1 for 2 cycles with both valids high → all outputs 0. On the first cycle after release, `ALU_OP_ADD` 3+4 from both requesters → `req0_ready`=1, `result`=7; next cycle `req1_ready`=1.
- Alternation: both requesters issue `ALU_OP_XOR` continuously for 6 cycles → ready order 0,1,0,1,0,1. With `ALU_ARB_STATS_EN`, `stat_conflict`=6 and `stat_grant0`=`stat_grant1`=3.
- Lock: `req0` issues `ALU_OP_MUL` 0x10000×0x10000 while `req1` issues `ALU_OP_ADD` 1+1 → `busy`=1 and `req1` is stalled for the full MUL duration. `req0_ready` arrives with `result`=0, `extra_result`=1; the next cycle gives `req1_ready` with `result`=2.
- Abort: `req1` issues `ALU_OP_DIV` 100/7 and drops valid 2 cycles in → `alu_valid`=0, no ready pulse, state back to IDLE, `last_grant` unchanged.
- Reset mid-DIV: assert `rst` during a LOCKED DIV → `busy`=0 next cycle, no ready pulse. A re-issued 100/7 then returns `result`=14, `extra_result`=2.
- Saturation (`ALU_ARB_STATS_EN`, `CNT_WIDTH`=4): 20 `req0` single-cycle ops → `stat_grant0`=15.

Source files
------------

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Two-requester round-robin arbiter placed directly in front of a shared ALU.
// Single-cycle ops complete combinationally in the cycle they are presented.
// Multi-cycle ops (MUL/DIV) lock the grant to the issuing requester until the
// ALU raises ready. The ALU's ready and results are steered back to the
// requester that owns the grant.
//
// Optional feature macro: ALU_ARB_STATS_EN
//   defined   -> saturating grant/conflict statistics counters are built
//   undefined -> stat_* outputs are constant 0; arbitration is unchanged
//
// Parameters:
//   WIDTH      operand/result width (must match the attached ALU)
//   CNT_WIDTH  width of the statistics counters
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   reqN_valid/op/a/b           request inputs from requester N (N = 0, 1)
//   reqN_ready                  completion pulse to requester N
//   result, extra_result        shared return bus, 0 unless a ready is high
//   alu_valid/op/a/b            request outputs to the ALU
//   alu_ready, alu_result,
//   alu_extra_result            completion inputs from the ALU
//   busy                        grant locked on an in-flight multi-cycle op
//   grant_id                    requester currently driving the ALU
//   stat_grant0/1, stat_conflict statistics counters
//
// Handshake: a requester raises reqN_valid and holds valid/op/a/b stable until
// the cycle in which reqN_ready is high; that cycle completes the transfer and
// result/extra_result are valid in the same cycle. The ALU side follows the
// same rule with alu_valid/alu_ready.
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  input  logic [7:0]           req0_op,
  input  logic [7:0]           req1_op,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 req0_ready,
  output logic                 req1_ready,
  output logic [WIDTH-1:0]     result,
  output logic [WIDTH-1:0]     extra_result,
  output logic                 alu_valid,
  output logic [7:0]           alu_op,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  input  logic                 alu_ready,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic [WIDTH-1:0]     alu_extra_result,
  output logic                 busy,
  output logic                 grant_id,
  output logic [CNT_WIDTH-1:0] stat_grant0,
  output logic [CNT_WIDTH-1:0] stat_grant1,
  output logic [CNT_WIDTH-1:0] stat_conflict
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  logic state_q, state_d;
  logic lock_id_q, lock_id_d;
  logic last_grant_q, last_grant_d;

  logic any_valid;
  logic winner;
  logic sel;
  logic sel_valid;
  logic drive;
  logic done;

  // ---------------------------------------------------------------------------
  // Selection and ALU steering
  // ---------------------------------------------------------------------------
  always_comb begin
    any_valid = req0_valid | req1_valid;
    // On a tie the requester that did not complete last wins; otherwise the
    // single valid requester wins (req1_valid alone selects 1).
    winner    = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    sel       = (state_q == ST_LOCKED) ? lock_id_q : winner;
    sel_valid = sel ? req1_valid : req0_valid;
    // In IDLE sel_valid equals any_valid; in LOCKED only the owner counts, so
    // a dropped owner valid deasserts the ALU request.
    drive     = ~rst & sel_valid;
    done      = drive & alu_ready;
  end

  // Operand muxes depend only on requester inputs and grant state, never on
  // the ALU result path.
  assign alu_valid    = drive;
  assign alu_op       = sel ? req1_op : req0_op;
  assign alu_a        = sel ? req1_a  : req0_a;
  assign alu_b        = sel ? req1_b  : req0_b;

  assign req0_ready   = done & ~sel;
  assign req1_ready   = done & sel;
  assign result       = done ? alu_result       : '0;
  assign extra_result = done ? alu_extra_result : '0;
  assign busy         = ~rst & (state_q == ST_LOCKED);
  assign grant_id     = ~rst & sel;

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    lock_id_d    = lock_id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          if (alu_ready) begin
            last_grant_d = winner;
          end else begin
            // Multi-cycle op in flight: pin the grant, pointer untouched.
            state_d   = ST_LOCKED;
            lock_id_d = winner;
          end
        end
      end
      ST_LOCKED: begin
        if (!sel_valid) begin
          // Owner abandoned its request: release without a completion.
          state_d = ST_IDLE;
        end else if (alu_ready) begin
          last_grant_d = lock_id_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lock_id_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      lock_id_q    <= lock_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef ALU_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] grant0_q, grant1_q, conflict_q;
  logic                 conflict_cyc;

  // Both valid and either one completes while the other waits, or both wait
  // behind a locked multi-cycle op.
  assign conflict_cyc = req0_valid & req1_valid & (done | (state_q == ST_LOCKED));

  always_ff @(posedge clk) begin
    if (rst) begin
      grant0_q   <= '0;
      grant1_q   <= '0;
      conflict_q <= '0;
    end else begin
      if (req0_ready && (grant0_q != '1)) begin
        grant0_q <= grant0_q + CNT_WIDTH'(1);
      end
      if (req1_ready && (grant1_q != '1)) begin
        grant1_q <= grant1_q + CNT_WIDTH'(1);
      end
      if (conflict_cyc && (conflict_q != '1)) begin
        conflict_q <= conflict_q + CNT_WIDTH'(1);
      end
    end
  end

  assign stat_grant0   = grant0_q;
  assign stat_grant1   = grant1_q;
  assign stat_conflict = conflict_q;
`else
  assign stat_grant0   = '0;
  assign stat_grant1   = '0;
  assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int WIDTH     = 32;
  localparam int CNT_WIDTH = 4;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_XOR = 8'h04;
  localparam logic [7:0] OP_MUL = 8'h20;
  localparam logic [7:0] OP_DIV = 8'h21;
  localparam int         MC_LAT = 4;

`ifdef ALU_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic                 req0_valid, req1_valid;
  logic [7:0]           req0_op, req1_op;
  logic [WIDTH-1:0]     req0_a, req0_b, req1_a, req1_b;
  logic                 req0_ready, req1_ready;
  logic [WIDTH-1:0]     result, extra_result;
  logic                 alu_valid;
  logic [7:0]           alu_op;
  logic [WIDTH-1:0]     alu_a, alu_b;
  logic                 alu_ready;
  logic [WIDTH-1:0]     alu_result, alu_extra_result;
  logic                 busy, grant_id;
  logic [CNT_WIDTH-1:0] stat_grant0, stat_grant1, stat_conflict;

  int n_cmp = 0;
  int n_err = 0;

  alu_arbiter #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .result(result), .extra_result(extra_result),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ready(alu_ready), .alu_result(alu_result), .alu_extra_result(alu_extra_result),
    .busy(busy), .grant_id(grant_id),
    .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // ALU model: ADD/XOR single-cycle, MUL/DIV ready in the MC_LAT-th cycle
  // ---------------------------------------------------------------------------
  logic [2:0]  mc_cnt;
  logic        is_multi;
  logic [63:0] prod;

  always_comb begin
    is_multi         = (alu_op == OP_MUL) || (alu_op == OP_DIV);
    prod             = {32'd0, alu_a} * {32'd0, alu_b};
    alu_result       = '0;
    alu_extra_result = '0;
    case (alu_op)
      OP_ADD: alu_result = alu_a + alu_b;
      OP_XOR: alu_result = alu_a ^ alu_b;
      OP_MUL: {alu_extra_result, alu_result} = prod;
      OP_DIV: begin
        alu_result       = (alu_b != 0) ? alu_a / alu_b : '1;
        alu_extra_result = (alu_b != 0) ? alu_a % alu_b : alu_a;
      end
      default: ;
    endcase
    alu_ready = alu_valid && (!is_multi || (mc_cnt == 3'(MC_LAT - 1)));
  end

  always @(posedge clk) begin
    if (rst || !alu_valid || alu_ready) mc_cnt <= '0;
    else if (is_multi)                  mc_cnt <= mc_cnt + 3'd1;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive0(input logic v, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic v, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios (each starts and ends 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive0(1'b1, OP_ADD, 32'd3, 32'd4);
    drive1(1'b1, OP_ADD, 32'd3, 32'd4);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({alu_valid, req0_ready, req1_ready, busy, grant_id} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b required 00000", {alu_valid, req0_ready, req1_ready, busy, grant_id});
    end
    n_cmp++;
    if ({result, extra_result} !== 64'd0) begin
      n_err++;
      $display("FAIL reset_result: got %h/%h required 0/0", result, extra_result);
    end
    n_cmp++;
    if ({stat_grant0, stat_grant1, stat_conflict} !== '0) begin
      n_err++;
      $display("FAIL reset_stats: got %0d/%0d/%0d required 0/0/0", stat_grant0, stat_grant1, stat_conflict);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10 || result !== 32'd7) begin
      n_err++;
      $display("FAIL first_tie: got r0=%b r1=%b res=%0d required r0=1 r1=0 res=7", req0_ready, req1_ready, result);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b01 || result !== 32'd7) begin
      n_err++;
      $display("FAIL second_tie: got r0=%b r1=%b res=%0d required r0=0 r1=1 res=7", req0_ready, req1_ready, result);
    end
    next_cycle();
    drive0(1'b0, OP_ADD, 0, 0);
    drive1(1'b0, OP_ADD, 0, 0);
  endtask

  task automatic test_alternation();
    logic exp_id;
    pulse_reset();
    drive0(1'b1, OP_XOR, 32'h0000_00F0, 32'h0000_000F);
    drive1(1'b1, OP_XOR, 32'h0000_0033, 32'h0000_000F);
    exp_id = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({req0_ready, req1_ready} !== {~exp_id, exp_id} || grant_id !== exp_id ||
          result !== (exp_id ? 32'h3C : 32'hFF)) begin
        n_err++;
        $display("FAIL alternation[%0d]: got r0=%b r1=%b gid=%b res=%h required gid=%b", k,
                 req0_ready, req1_ready, grant_id, result, exp_id);
      end
      exp_id = ~exp_id;
      next_cycle();
    end
    drive0(1'b0, OP_XOR, 0, 0);
    drive1(1'b0, OP_XOR, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (stat_grant0 !== (STATS ? 4'd3 : 4'd0) || stat_grant1 !== (STATS ? 4'd3 : 4'd0) ||
        stat_conflict !== (STATS ? 4'd6 : 4'd0)) begin
      n_err++;
      $display("FAIL alt_stats: got g0=%0d g1=%0d cf=%0d required %0d/%0d/%0d", stat_grant0, stat_grant1,
               stat_conflict, STATS ? 3 : 0, STATS ? 3 : 0, STATS ? 6 : 0);
    end
    next_cycle();
  endtask

  task automatic test_lock();
    // last completion was req1, so req0 wins the tie and locks on MUL
    drive0(1'b1, OP_MUL, 32'h0001_0000, 32'h0001_0000);
    drive1(1'b1, OP_ADD, 32'd1, 32'd1);
    @(negedge clk);
    n_cmp++;
    if ({alu_valid, grant_id, busy, req0_ready, req1_ready} !== 5'b10000) begin
      n_err++;
      $display("FAIL lock_issue: got v/gid/busy/r0/r1=%b required 10000", {alu_valid, grant_id, busy, req0_ready, req1_ready});
    end
    next_cycle();
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, grant_id, req0_ready, req1_ready} !== 4'b1000) begin
        n_err++;
        $display("FAIL lock_hold[%0d]: got busy/gid/r0/r1=%b required 1000", c, {busy, grant_id, req0_ready, req1_ready});
      end
      next_cycle();
    end
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10 || result !== 32'd0 || extra_result !== 32'd1) begin
      n_err++;
      $display("FAIL lock_done: got r0=%b r1=%b res=%h ext=%h required 1 0 0 1", req0_ready, req1_ready, result, extra_result);
    end
    next_cycle();
    drive0(1'b0, OP_MUL, 0, 0);
    @(negedge clk);
    n_cmp++;
    if ({req1_ready, busy} !== 2'b10 || result !== 32'd2) begin
      n_err++;
      $display("FAIL lock_next: got r1=%b busy=%b res=%0d required r1=1 busy=0 res=2", req1_ready, busy, result);
    end
    next_cycle();
    drive1(1'b0, OP_ADD, 0, 0);
  endtask

  task automatic test_abort();
    drive0(1'b1, OP_ADD, 32'd5, 32'd6);
    @(negedge clk);
    n_cmp++;
    if (req0_ready !== 1'b1 || result !== 32'd11) begin
      n_err++;
      $display("FAIL abort_pre: got r0=%b res=%0d required r0=1 res=11", req0_ready, result);
    end
    next_cycle();
    drive0(1'b0, OP_ADD, 0, 0);
    drive1(1'b1, OP_DIV, 32'd100, 32'd7);
    @(negedge clk);
    n_cmp++;
    if ({alu_valid, grant_id, busy, req1_ready} !== 4'b1100) begin
      n_err++;
      $display("FAIL abort_issue: got v/gid/busy/r1=%b required 1100", {alu_valid, grant_id, busy, req1_ready});
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({alu_valid, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL abort_locked: got v/busy=%b required 11", {alu_valid, busy});
    end
    next_cycle();
    drive1(1'b0, OP_DIV, 32'd100, 32'd7);
    @(negedge clk);
    n_cmp++;
    if ({alu_valid, req0_ready, req1_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL abort_drop: got v/r0/r1=%b required 000", {alu_valid, req0_ready, req1_ready});
    end
    next_cycle();
    // Pointer must still be 0 (req0 completed last), so req1 wins this tie.
    drive0(1'b1, OP_ADD, 32'd2, 32'd2);
    drive1(1'b1, OP_ADD, 32'd3, 32'd3);
    @(negedge clk);
    n_cmp++;
    if ({busy, req0_ready, req1_ready} !== 3'b001 || result !== 32'd6) begin
      n_err++;
      $display("FAIL abort_after: got busy/r0/r1=%b res=%0d required 001 res=6", {busy, req0_ready, req1_ready}, result);
    end
    next_cycle();
    drive0(1'b0, OP_ADD, 0, 0);
    drive1(1'b0, OP_ADD, 0, 0);
  endtask

  task automatic test_reset_mid_div();
    bit got;
    int lat;
    drive0(1'b1, OP_DIV, 32'd100, 32'd7);
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL middiv_locked: got busy=%b required 1", busy);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, alu_valid, req0_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL middiv_rst: got busy/v/r0=%b required 000", {busy, alu_valid, req0_ready});
    end
    next_cycle();
    rst = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL middiv_release: got busy=%b required 0", busy);
        end
      end
      if (req0_ready === 1'b1) begin
        got = 1'b1;
        lat = i;
        n_cmp++;
        if (result !== 32'd14 || extra_result !== 32'd2) begin
          n_err++;
          $display("FAIL middiv_result: got %0d r %0d required 14 r 2", result, extra_result);
        end
      end
      next_cycle();
    end
    n_cmp++;
    if (!got || lat != MC_LAT) begin
      n_err++;
      $display("FAIL middiv_latency: got seen=%0d cycles=%0d required seen=1 cycles=%0d", got, lat, MC_LAT);
    end
    drive0(1'b0, OP_DIV, 0, 0);
  endtask

  task automatic test_saturation();
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      drive0(1'b1, OP_ADD, 32'(i), 32'd1);
      @(negedge clk);
      n_cmp++;
      if (req0_ready !== 1'b1 || result !== 32'(i + 1)) begin
        n_err++;
        $display("FAIL sat_op[%0d]: got r0=%b res=%0d required r0=1 res=%0d", i, req0_ready, result, i + 1);
      end
      next_cycle();
    end
    drive0(1'b0, OP_ADD, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (stat_grant0 !== (STATS ? 4'd15 : 4'd0) || stat_grant1 !== 4'd0) begin
      n_err++;
      $display("FAIL sat_stats: got g0=%0d g1=%0d required g0=%0d g1=0", stat_grant0, stat_grant1, STATS ? 15 : 0);
    end
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    drive0(1'b0, OP_ADD, 0, 0);
    drive1(1'b0, OP_ADD, 0, 0);
    test_reset();
    test_alternation();
    test_lock();
    test_abort();
    test_reset_mid_div();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
